// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), LSB first, fixed-length transfers.
// Each transfer runs LEAD, then WIDTH pairs of HIGH/LOW phases; the final LOW
// phase is the trailing phase that precedes the return of ss to high.
module spi_master #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned CLKDIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             ss
);

    localparam int unsigned PW = $clog2(CLKDIV + 1);
    localparam int unsigned IW = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] PhaseLast = PW'(CLKDIV - 1);
    localparam logic [IW-1:0] IdxLast   = IW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StLead, StHigh, StLow} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             ss_q, ss_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             phase_end;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] rx_next;

    assign phase_end = (phase_q == PhaseLast);

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        ss_d    = ss_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // tx_q is shifted right after every bit, so bit 0 is always the one on mosi.
        tx_next = tx_q >> 1;
        // Shift right with miso entering at the top: after WIDTH captures the
        // first captured bit has reached bit 0.
        rx_next            = rx_sh_q >> 1;
        rx_next[WIDTH-1]   = miso;

        case (state_q)
            StIdle: begin
                if (start) begin
                    tx_d    = tx_data;
                    rx_sh_d = '0;
                    ss_d    = 1'b0;
                    mosi_d  = tx_data[0];
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    phase_d = '0;
                    state_d = StLead;
                end
            end
            StLead, StLow: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (idx_q == IdxLast) begin
                        // Trailing phase complete: release the slave.
                        ss_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        rx_d    = rx_sh_q;
                        state_d = StIdle;
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sh_d = rx_next;
                        state_d = StHigh;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StHigh: begin
                if (phase_end) begin
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    idx_d   = idx_q + 1'b1;
                    tx_d    = tx_next;
                    // After the last bit mosi simply holds its value.
                    if (idx_d != IdxLast) begin
                        mosi_d = tx_next[0];
                    end
                    state_d = StLow;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            phase_q <= '0;
            idx_q   <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ss_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ss_q    <= ss_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss      = ss_q;

endmodule
